// File: rtl/sccb_master.sv
// sccb_master - SCCB (OV7670-class) camera-control master with XCLK generator.
//
// Runs one register transaction per accepted start pulse:
//   write: START, {id,0}+X, sub_addr byte(s)+X, wr_data+X, STOP
//   read : START, {id,0}+X, sub_addr byte(s)+X, STOP, GAP,
//          START, {id,1}+X, 8 read bits, NA, STOP
// Every bus state lasts four SIOC quarters of CLK_DIV clk cycles each.
//
// Ports:
//   clk, DEVRST_N          system clock, asynchronous active-low reset
//   start, rw              request pulse (taken only when idle), 0=write 1=read
//   dev_id, sub_addr       7-bit slave ID, register address (MSB byte first)
//   wr_data                write data byte
//   busy, done             transaction in progress, one-cycle completion pulse
//   rd_data, ack_err       read result, sticky "X-bit sampled high" flag
//   sio_c                  SIOC pin
//   sio_d_out, sio_d_oe    SIOD drive value and enable (tristate lives above)
//   sio_d_in               SIOD pad input (asynchronous)
//   xclk                   free-running camera clock, f_clk/XCLK_DIV
module sccb_master #(
  parameter int CLK_DIV    = 125,
  parameter int ADDR_BYTES = 1,
  parameter int XCLK_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    DEVRST_N,
  input  logic                    start,
  input  logic                    rw,
  input  logic [6:0]              dev_id,
  input  logic [8*ADDR_BYTES-1:0] sub_addr,
  input  logic [7:0]              wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              rd_data,
  output logic                    ack_err,
  output logic                    sio_c,
  output logic                    sio_d_out,
  output logic                    sio_d_oe,
  input  logic                    sio_d_in,
  output logic                    xclk
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int XH = XCLK_DIV / 2;
  localparam int XW = (XH > 1) ? $clog2(XH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TXBIT, S_XBIT, S_RXBIT, S_NA, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t                  state, state_nx;
  logic [QW-1:0]           qcnt;
  logic [1:0]              quarter;
  logic                    tick, q_end, accept;
  logic                    rw_q;
  logic [6:0]              id_q;
  logic [8*ADDR_BYTES-1:0] sub_q;
  logic [7:0]              wr_q;
  logic [2:0]              bit_cnt;
  logic [1:0]              byte_idx, last_idx;
  logic                    second;   // in the read phase after the GAP
  logic [1:0]              sync;
  logic [7:0]              cur_byte;
  logic [XW-1:0]           xcnt;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign accept   = start && (state == S_IDLE);
  assign tick     = (state != S_IDLE) && (state != S_DONE) && (qcnt == QW'(CLK_DIV - 1));
  assign q_end    = tick && (quarter == 2'd3);
  assign last_idx = rw_q ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1);

  // Byte on the bus: index 0 is the device address, then sub-address bytes
  // MSB first, then write data. The post-GAP phase always sends {id,1}.
  always_comb begin
    cur_byte = wr_q;
    if (second) begin
      cur_byte = {id_q, 1'b1};
    end else if (byte_idx == 2'd0) begin
      cur_byte = {id_q, 1'b0};
    end else begin
      for (int unsigned i = 0; i < ADDR_BYTES; i++) begin
        if (byte_idx == 2'(i + 1)) cur_byte = sub_q[8*(ADDR_BYTES-1-i) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge DEVRST_N) begin
    if (!DEVRST_N) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sio_c     = 1'b1;
    sio_d_out = 1'b1;
    sio_d_oe  = 1'b1;
    case (state)
      S_IDLE:  if (start) state_nx = S_START;
      S_START: begin
        sio_c     = (quarter != 2'd3);
        sio_d_out = ~quarter[1];
        if (q_end) state_nx = S_TXBIT;
      end
      S_TXBIT: begin
        sio_c     = quarter[1];
        sio_d_out = cur_byte[~bit_cnt];
        if (q_end && bit_cnt == 3'd7) state_nx = S_XBIT;
      end
      S_XBIT: begin
        sio_c    = quarter[1];
        sio_d_oe = 1'b0;
        if (q_end) begin
          if (second)                    state_nx = S_RXBIT;
          else if (byte_idx == last_idx) state_nx = S_STOP;
          else                           state_nx = S_TXBIT;
        end
      end
      S_RXBIT: begin
        sio_c    = quarter[1];
        sio_d_oe = 1'b0;
        if (q_end && bit_cnt == 3'd7) state_nx = S_NA;
      end
      S_NA: begin
        sio_c = quarter[1];
        if (q_end) state_nx = S_STOP;
      end
      S_STOP: begin
        sio_c     = (quarter != 2'd0);
        sio_d_out = (quarter == 2'd3);
        if (q_end) state_nx = (rw_q && !second) ? S_GAP : S_DONE;
      end
      S_GAP:   if (q_end) state_nx = S_START;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Quarter timebase; quarter wraps naturally since every timed state is 4 long.
  always_ff @(posedge clk or negedge DEVRST_N) begin
    if (!DEVRST_N) begin
      qcnt    <= '0;
      quarter <= '0;
    end else if (state == S_IDLE || state == S_DONE) begin
      qcnt    <= '0;
      quarter <= '0;
    end else if (tick) begin
      qcnt    <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      qcnt    <= qcnt + QW'(1);
    end
  end

  always_ff @(posedge clk or negedge DEVRST_N) begin
    if (!DEVRST_N) sync <= '1;
    else           sync <= {sync[0], sio_d_in};
  end

  always_ff @(posedge clk or negedge DEVRST_N) begin
    if (!DEVRST_N) begin
      rw_q     <= 1'b0;
      id_q     <= '0;
      sub_q    <= '0;
      wr_q     <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      second   <= 1'b0;
      rd_data  <= '0;
      ack_err  <= 1'b0;
    end else if (accept) begin
      rw_q     <= rw;
      id_q     <= dev_id;
      sub_q    <= sub_addr;
      wr_q     <= wr_data;
      bit_cnt  <= '0;
      byte_idx <= '0;
      second   <= 1'b0;
      rd_data  <= '0;
      ack_err  <= 1'b0;
    end else begin
      // SIOD is sampled on the tick that ends Q2, mid SIOC-high.
      if (tick && quarter == 2'd2) begin
        if (state == S_XBIT && sync[1]) ack_err <= 1'b1;
        if (state == S_RXBIT)           rd_data <= {rd_data[6:0], sync[1]};
      end
      if (q_end) begin
        case (state)
          S_TXBIT, S_RXBIT: bit_cnt  <= bit_cnt + 3'd1;
          S_XBIT:           byte_idx <= byte_idx + 2'd1;
          S_GAP:            second   <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge DEVRST_N) begin
    if (!DEVRST_N) begin
      xcnt <= '0;
      xclk <= 1'b0;
    end else if (xcnt == XW'(XH - 1)) begin
      xcnt <= '0;
      xclk <= ~xclk;
    end else begin
      xcnt <= xcnt + XW'(1);
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master - scoreboard bench for sccb_master.
// u0: CLK_DIV=4, ADDR_BYTES=1, XCLK_DIV=2.  u1: CLK_DIV=4, ADDR_BYTES=2, XCLK_DIV=4.
// A bus decoder (with a small slave model) turns SIOC/SIOD into events and
// compares them with the expected-event queue; a done monitor compares each
// completion against the expected-response queues.
module tb_sccb_master;

  localparam int EV_START = 1000;
  localparam int EV_STOP  = 1001;
  localparam int NACK     = 256;   // X-bit released and sampled high
  localparam int NA       = 768;   // ninth bit driven 1 by the master

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        DEVRST_N, start0, start1, rw;
  logic [6:0]  dev_id;
  logic [15:0] sub;
  logic [7:0]  wdat;
  logic        busy0, done0, ack0, c0, d0, oe0, x0, pad0;
  logic        busy1, done1, ack1, c1, d1, oe1, x1, pad1;
  logic [7:0]  rd0, rd1;
  logic        sel, slv_oe, slv_val, silent, abort;
  logic [7:0]  slv_byte;
  logic        mon_c, mon_d, mon_oe, busy_m, done_m, ack_m;
  logic [7:0]  rd_m;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_bus[$];
  int exp_rd[$];
  int exp_ack[$];
  int exp_lat[$];
  int acc_q[$];

  sccb_master #(.CLK_DIV(4), .ADDR_BYTES(1), .XCLK_DIV(2)) u0 (
    .clk(clk), .DEVRST_N(DEVRST_N), .start(start0), .rw(rw), .dev_id(dev_id),
    .sub_addr(sub[7:0]), .wr_data(wdat), .busy(busy0), .done(done0), .rd_data(rd0),
    .ack_err(ack0), .sio_c(c0), .sio_d_out(d0), .sio_d_oe(oe0), .sio_d_in(pad0), .xclk(x0));

  sccb_master #(.CLK_DIV(4), .ADDR_BYTES(2), .XCLK_DIV(4)) u1 (
    .clk(clk), .DEVRST_N(DEVRST_N), .start(start1), .rw(rw), .dev_id(dev_id),
    .sub_addr(sub), .wr_data(wdat), .busy(busy1), .done(done1), .rd_data(rd1),
    .ack_err(ack1), .sio_c(c1), .sio_d_out(d1), .sio_d_oe(oe1), .sio_d_in(pad1), .xclk(x1));

  // Open-drain style pad with pull-up: master wins when enabled.
  assign pad0   = oe0 ? d0 : ((!sel && slv_oe) ? slv_val : 1'b1);
  assign pad1   = oe1 ? d1 : (( sel && slv_oe) ? slv_val : 1'b1);
  assign mon_c  = sel ? c1 : c0;
  assign mon_d  = sel ? pad1 : pad0;
  assign mon_oe = sel ? oe1 : oe0;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign ack_m  = sel ? ack1 : ack0;
  assign rd_m   = sel ? rd1 : rd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic bus_check(input int ev);
    if (exp_bus.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL bus_unexpected: observed event 0x%0h with nothing pending", ev);
    end else begin
      chk("bus_event", ev, exp_bus.pop_front());
    end
  endtask

  // Bus decoder + slave: samples pins on the falling clk edge, away from DUT updates.
  initial begin : decoder
    logic pc, pd, c, d, first_byte, slave_tx, in_frame, rx_byte;
    int bitn;
    logic [7:0] shreg;
    pc = 1'b1; pd = 1'b1; first_byte = 1'b0; slave_tx = 1'b0; in_frame = 1'b0;
    bitn = 0; shreg = '0; slv_oe = 1'b0; slv_val = 1'b1;
    forever begin
      @(negedge clk);
      c = mon_c;
      d = mon_d;
      if (abort) begin
        in_frame = 1'b0;
        bitn = 0;
        slv_oe = 1'b0;
      end else if (pc && c && pd && !d) begin
        bus_check(EV_START);
        in_frame = 1'b1; bitn = 0; first_byte = 1'b1; slave_tx = 1'b0; slv_oe = 1'b0;
      end else if (pc && c && !pd && d && in_frame) begin
        bus_check(EV_STOP);
        in_frame = 1'b0;
        slv_oe = 1'b0;
      end else if (!pc && c && in_frame) begin
        if (bitn < 8) begin
          shreg = {shreg[6:0], d};
          bitn++;
        end else begin
          bus_check(int'(shreg) + 256 * int'({mon_oe, d}));
          if (first_byte) slave_tx = shreg[0];
          first_byte = 1'b0;
          bitn = 0;
        end
      end else if (pc && !c && in_frame) begin
        rx_byte = !first_byte && slave_tx;
        if (bitn == 8) begin
          slv_oe  = !rx_byte && !silent;
          slv_val = 1'b0;
        end else begin
          slv_oe  = rx_byte;
          slv_val = slv_byte[7 - bitn];
        end
      end
      pc = c;
      pd = d;
    end
  end

  initial begin : done_monitor
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        chk("busy_after_done", busy_m, 0);
        chk("done_one_cycle", done_m, 0);
      end
      if (done_m) begin
        if (exp_rd.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: done pulsed with no pending request at t=%0t", $time);
        end else begin
          chk("rd_data", rd_m, exp_rd.pop_front());
          chk("ack_err", ack_m, exp_ack.pop_front());
          chk("latency", cyc - acc_q.pop_front(), exp_lat.pop_front());
        end
      end
      prev_done = done_m;
    end
  end

  task automatic expect_rsp(input int rd, input int ack, input int lat_clks);
    exp_rd.push_back(rd);
    exp_ack.push_back(ack);
    exp_lat.push_back(lat_clks);
  endtask

  task automatic run(input bit s1, input bit r, input logic [6:0] id, input logic [15:0] sa,
                     input logic [7:0] wd, input int lat_q, input bit shape, input bit spam);
    int n, q;
    int ss[4];
    int sp[4];
    ss = '{3, 3, 2, 0};
    sp = '{0, 2, 2, 3};
    sel = s1;
    @(negedge clk);
    rw = r; dev_id = id; sub = sa; wdat = wd;
    if (s1) start1 = 1'b1;
    else    start0 = 1'b1;
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    n = 0;
    while (busy_m && n < lat_q * 4 + 20) begin
      q = n / 4;
      if (n == 2) begin
        chk("clr_ack_err", ack_m, 0);
        chk("clr_rd_data", rd_m, 0);
      end
      if (shape && (n % 4) == 1) begin
        if (q < 4) chk("start_shape", int'({c0, d0}), ss[q]);
        else if (q >= lat_q - 4 && q < lat_q) chk("stop_shape", int'({c0, d0}), sp[q - (lat_q - 4)]);
      end
      if (spam) begin
        if ((n % 100) == 10) begin
          start0 = 1'b1; rw = 1'b1; dev_id = 7'h55; sub = 16'h00FF; wdat = 8'h01;
        end else begin
          start0 = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    start0 = 1'b0;
    if (busy_m) begin
      errors++;
      checks++;
      $display("FAIL timeout: transaction still busy after %0d cycles", n);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic v;
    DEVRST_N = 1'b0; start0 = 1'b0; start1 = 1'b0; rw = 1'b0; dev_id = '0; sub = '0;
    wdat = '0; sel = 1'b0; silent = 1'b0; abort = 1'b0; slv_byte = 8'h76;
    #23;
    chk("rst_sio_c", c0, 1);
    chk("rst_sio_d_out", d0, 1);
    chk("rst_sio_d_oe", oe0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_rd_data", rd0, 0);
    chk("rst_ack_err", ack0, 0);
    chk("rst_xclk0", x0, 0);
    chk("rst_xclk1", x1, 0);
    chk("rst_sio_c1", c1, 1);
    @(negedge clk);
    DEVRST_N = 1'b1;
    repeat (3) @(negedge clk);

    // Write 0x80 to 0x12, slave acks everything.
    exp_bus = '{EV_START, 8'h42, 8'h12, 8'h80, EV_STOP};
    expect_rsp(0, 0, 464);
    run(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80, 116, 1'b1, 1'b0);

    // Read 0x0A, slave returns 0x76.
    slv_byte = 8'h76;
    exp_bus = '{EV_START, 8'h42, 8'h0A, EV_STOP, EV_START, 8'h43, 8'h76 + NA, EV_STOP};
    expect_rsp(8'h76, 0, 656);
    run(1'b0, 1'b1, 7'h21, 16'h000A, 8'h00, 164, 1'b0, 1'b0);

    // Silent slave: every X bit reads high, transaction still completes.
    silent = 1'b1;
    exp_bus = '{EV_START, 8'h42 + NACK, 8'h11 + NACK, 8'h22 + NACK, EV_STOP};
    expect_rsp(0, 1, 464);
    run(1'b0, 1'b0, 7'h21, 16'h0011, 8'h22, 116, 1'b0, 1'b0);
    silent = 1'b0;
    repeat (5) @(negedge clk);
    chk("ack_err_sticky", ack0, 1);

    // Start pulsed repeatedly while busy with different inputs.
    exp_bus = '{EV_START, 8'h42, 8'h33, 8'h5A, EV_STOP};
    expect_rsp(0, 0, 464);
    run(1'b0, 1'b0, 7'h21, 16'h0033, 8'h5A, 116, 1'b0, 1'b1);

    // Reset during the 3rd bit of the data byte.
    exp_bus = '{EV_START, 8'h42, 8'h12};
    sel = 1'b0;
    @(negedge clk);
    rw = 1'b0; dev_id = 7'h21; sub = 16'h0012; wdat = 8'h80; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (341) @(negedge clk);
    chk("busy_before_abort", busy0, 1);
    abort = 1'b1;
    #2;
    DEVRST_N = 1'b0;
    #1;
    chk("abort_sio_c", c0, 1);
    chk("abort_sio_d_oe", oe0, 1);
    chk("abort_sio_d_out", d0, 1);
    chk("abort_busy", busy0, 0);
    @(negedge clk);
    DEVRST_N = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("abort_bus_events", exp_bus.size(), 0);

    // Read after reset.
    slv_byte = 8'hC5;
    exp_bus = '{EV_START, 8'h42, 8'h5B, EV_STOP, EV_START, 8'h43, 8'hC5 + NA, EV_STOP};
    expect_rsp(8'hC5, 0, 656);
    run(1'b0, 1'b1, 7'h21, 16'h005B, 8'h00, 164, 1'b0, 1'b0);

    // u0 xclk toggles every clk.
    @(negedge clk);
    v = x0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("xclk0_wave", x0, int'(v ^ k[0]));
    end

    // Two-byte sub-address on u1.
    exp_bus = '{EV_START, 8'h42, 8'h30, 8'h12, 8'h9C, EV_STOP};
    expect_rsp(0, 0, 608);
    run(1'b1, 1'b0, 7'h21, 16'h3012, 8'h9C, 152, 1'b0, 1'b0);

    // u1 xclk: period 4 clks, 50% duty.
    @(negedge clk);
    v = x1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (x1 != v) break;
    end
    v = x1;
    for (int k = 0; k < 12; k++) begin
      chk("xclk1_wave", x1, int'(v ^ k[1]));
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("rsp_queue_drained", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
